// File: rtl/contador_param.sv
// Modulo-N up/down counter with prescaler, clear/load, terminal-count pulse and decimal 7-seg output.
// Optional leading-zero blanking on the display is enabled by defining CONTADOR_BLANK_LEADING_EN.
module contador_param #(
  parameter  int unsigned CLK_HZ  = 50000000,
  parameter  int unsigned TICK_HZ = 1,
  parameter  int unsigned MODULO  = 9,
  parameter  int unsigned DIGITS  = 1,
  localparam int unsigned CW      = (MODULO <= 2) ? 1 : $clog2(MODULO)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                DIR,
  input  logic                CLR,
  input  logic                LOAD,
  input  logic [CW-1:0]       LOAD_VAL,
  output logic [CW-1:0]       COUNT,
  output logic                TICK,
  output logic                TC,
  output logic [7*DIGITS-1:0] HEX
);

  localparam int unsigned   TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned   PW       = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam int unsigned   BW       = 4 * DIGITS;
  localparam int unsigned   HW       = 7 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MODULO - 1);
`ifdef CONTADOR_BLANK_LEADING_EN
  localparam logic [HW-1:0] HEX_RST  = ({DIGITS{7'h7F}} & ~HW'(7'h7F)) | HW'(7'h40);
`else
  localparam logic [HW-1:0] HEX_RST  = {DIGITS{7'h40}};
`endif

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q, tc_d;
  logic [HW-1:0] hex_q, hex_d;
  logic [BW-1:0] bcd;
  logic [CW-1:0] sh;
  logic          tick;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Gated by RST_N so TICK reads 0 during reset even when TICK_DIV is 1.
  assign tick = RST_N & EN & (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (CLR) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (LOAD) begin
      pre_d = '0;
      cnt_d = (LOAD_VAL > CNT_MAX) ? CNT_MAX : LOAD_VAL;
    end else begin
      if (EN) pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (DIR) begin
          if (cnt_q >= CNT_MAX) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d = CNT_MAX;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  // Double-dabble: add 3 to any digit >= 5, then shift in the next count bit.
  always_comb begin
    bcd = '0;
    sh  = cnt_q;
    for (int unsigned i = 0; i < CW; i++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[BW-2:0], sh[CW-1]};
      sh  = sh << 1;
    end
  end

`ifdef CONTADOR_BLANK_LEADING_EN
  logic lead;
`endif

  always_comb begin
    hex_d = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      hex_d[7*d +: 7] = seg7(bcd[4*d +: 4]);
    end
`ifdef CONTADOR_BLANK_LEADING_EN
    lead = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (bcd[4*k +: 4] == 4'd0)) hex_d[7*k +: 7] = 7'h7F;
      else                                 lead = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q <= '0;
      cnt_q <= '0;
      tc_q  <= 1'b0;
      hex_q <= HEX_RST;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      hex_q <= hex_d;
    end
  end

  assign COUNT = cnt_q;
  assign TICK  = tick;
  assign TC    = tc_q;
  assign HEX   = hex_q;

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param with TICK_DIV=10, MODULO=12, DIGITS=2.
module tb_contador_param;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        DIR;
  logic        CLR;
  logic        LOAD;
  logic [3:0]  LOAD_VAL;
  logic [3:0]  COUNT;
  logic        TICK;
  logic        TC;
  logic [13:0] HEX;

  int total = 0;
  int bad   = 0;

  contador_param #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .MODULO (12),
    .DIGITS (2)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .DIR     (DIR),
    .CLR     (CLR),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .COUNT   (COUNT),
    .TICK    (TICK),
    .TC      (TC),
    .HEX     (HEX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        clr;
    logic        load;
    logic [3:0]  lv;
    logic        en;
    logic        dir;
    int unsigned ncyc;
    logic [3:0]  cnt;
    logic        tc;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [6:0] seg(input int unsigned d);
    case (d)
      0:       seg = 7'h40;
      1:       seg = 7'h79;
      2:       seg = 7'h24;
      3:       seg = 7'h30;
      4:       seg = 7'h19;
      5:       seg = 7'h12;
      6:       seg = 7'h02;
      7:       seg = 7'h78;
      8:       seg = 7'h00;
      9:       seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] hex_exp(input int unsigned n);
    logic [6:0] hi;
    logic [6:0] lo;
    hi = seg(n / 10);
    lo = seg(n % 10);
`ifdef CONTADOR_BLANK_LEADING_EN
    if (n < 10) hi = 7'h7F;
`endif
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      edge1();
      if (TICK) seen = 1'b1;
    end
    chk("tick_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_step(input string nm, input logic [3:0] exp_cnt, input logic exp_tc);
    wait_tick();
    edge1();
    chk({nm, "_count"}, 32'(COUNT), 32'(exp_cnt));
    chk({nm, "_tc"}, 32'(TC), 32'(exp_tc));
  endtask

  initial begin
    // {clr, load, lv, en, dir, ncyc, expected count, expected tc}
    tbl[0]  = '{1'b0, 1'b1, 4'd7,  1'b0, 1'b1, 1,  4'd7,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1,  4'd11, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1,  4'd0,  1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 1,  4'd0,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 1,  4'd11, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1,  4'd11, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1,  4'd0,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1,  4'd3,  1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 5,  4'd3,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 10, 4'd4,  1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1,  4'd0,  1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 10, 4'd11, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 10, 4'd0,  1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 3,  4'd0,  1'b0};

    RST_N = 1'b0; EN = 1'b0; DIR = 1'b1; CLR = 1'b0; LOAD = 1'b0; LOAD_VAL = 4'd0;
    repeat (3) edge1();
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_tick", 32'(TICK), 32'd0);
    chk("rst_tc", 32'(TC), 32'd0);
    chk("rst_hex", 32'(HEX), 32'(hex_exp(0)));

    // Count up across a full wrap; edge c lands with prescaler = c mod 10.
    RST_N = 1'b1; EN = 1'b1; DIR = 1'b1;
    for (int unsigned c = 1; c <= 125; c++) begin
      edge1();
      chk("up_tick", 32'(TICK), 32'(c % 10 == 9));
      chk("up_count", 32'(COUNT), (c / 10) % 12);
      chk("up_tc", 32'(TC), 32'(c == 120));
      if (c % 10 == 1 && c > 10) chk("up_hex", 32'(HEX), 32'(hex_exp(((c - 1) / 10) % 12)));
    end

    DIR = 1'b0;
    wait_step("down_wrap", 4'd11, 1'b1);
    wait_step("down_10", 4'd10, 1'b0);
    edge1();
    chk("down_hex", 32'(HEX), 32'(hex_exp(10)));

    // Mid-period load restarts the prescaler.
    LOAD = 1'b1; LOAD_VAL = 4'd7;
    edge1();
    chk("load_count", 32'(COUNT), 32'd7);
    LOAD = 1'b0; DIR = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      edge1();
      chk("load_hold", 32'(COUNT), 32'd7);
    end
    edge1();
    chk("load_step10", 32'(COUNT), 32'd8);

    for (int i = 0; i < 14; i++) begin
      CLR = tbl[i].clr; LOAD = tbl[i].load; LOAD_VAL = tbl[i].lv;
      EN = tbl[i].en; DIR = tbl[i].dir;
      for (int unsigned n = 0; n < tbl[i].ncyc; n++) edge1();
      chk($sformatf("vec%0d_count", i), 32'(COUNT), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_tc", i), 32'(TC), 32'(tbl[i].tc));
    end
    CLR = 1'b0; LOAD = 1'b0;

    // CLR coincident with a wrapping tick.
    LOAD = 1'b1; LOAD_VAL = 4'd11;
    edge1();
    LOAD = 1'b0;
    chk("prio_preload", 32'(COUNT), 32'd11);
    EN = 1'b1; DIR = 1'b1;
    wait_tick();
    CLR = 1'b1;
    edge1();
    chk("prio_clr_count", 32'(COUNT), 32'd0);
    chk("prio_clr_tc", 32'(TC), 32'd0);
    CLR = 1'b0;

    // Enable freeze at prescaler 4.
    repeat (4) edge1();
    chk("en_pre_tick", 32'(TICK), 32'd0);
    EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      chk("en_frozen_count", 32'(COUNT), 32'd0);
      chk("en_frozen_tick", 32'(TICK), 32'd0);
    end
    EN = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      edge1();
      chk("en_resume_tick", 32'(TICK), 32'(i == 5));
    end
    edge1();
    chk("en_step", 32'(COUNT), 32'd1);

    EN = 1'b0;
    LOAD = 1'b1; LOAD_VAL = 4'd5;
    edge1();
    LOAD = 1'b0;
    chk("five_count", 32'(COUNT), 32'd5);
    edge1();
    chk("five_hex", 32'(HEX), 32'(hex_exp(5)));

    // Asynchronous reset between edges.
    LOAD = 1'b1; LOAD_VAL = 4'd9;
    edge1();
    LOAD = 1'b0;
    edge1();
    chk("nine_hex", 32'(HEX), 32'(hex_exp(9)));
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_count", 32'(COUNT), 32'd0);
    chk("arst_tc", 32'(TC), 32'd0);
    chk("arst_tick", 32'(TICK), 32'd0);
    chk("arst_hex", 32'(HEX), 32'(hex_exp(0)));
    edge1();
    RST_N = 1'b1;
    edge1();
    chk("post_rst_count", 32'(COUNT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
